// File: rtl/dlsc_demosaic_vng_seqrom.sv
// rtl/dlsc_demosaic_vng_seqrom.sv - sequenced multi-channel coefficient ROM for VNG demosaic
// Optional feature macro: DLSC_DEMOSAIC_VNG_SEQROM_LOOP_EN (back-to-back sequences without an IDLE gap)
module dlsc_demosaic_vng_seqrom #(
  parameter int DATA     = 4,
  parameter int STATES   = 12,
  parameter int SB       = 4,
  parameter int CHANNELS = 1,
  parameter logic [DATA*CHANNELS*STATES-1:0] ROM = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_start,
  input  logic                     in_en,
  output logic                     out_valid,
  output logic [SB-1:0]            out_st,
  output logic [DATA*CHANNELS-1:0] out_data,
  output logic                     out_last,
  output logic                     out_done,
  output logic                     busy
);

  localparam int W = DATA*CHANNELS;
  localparam logic [SB-1:0] ST_LAST = SB'(STATES-1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [SB-1:0] st_q, st_d;
  logic [SB-1:0] out_st_q, out_st_d;
  logic [W-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic [W-1:0]  entry;

  // Decode the current state's ROM entry; state 0 lives in the most-significant slot
  always_comb begin
    entry = '0;
    for (int s = 0; s < STATES; s++) begin
      if (st_q == SB'(s)) begin
        entry = ROM[W*(STATES-1-s) +: W];
      end
    end
  end

  // Sequencer next-state and output-register inputs; outputs hold while stalled
  always_comb begin
    state_d  = state_q;
    st_d     = st_q;
    out_st_d = out_st_q;
    data_d   = data_q;
    last_d   = last_q;
    valid_d  = 1'b0;
    // done marks the cycle after the final word was presented
    done_d   = valid_q & last_q;
    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          state_d = S_RUN;
          st_d    = '0;
        end
      end
      S_RUN: begin
        if (in_en) begin
          valid_d  = 1'b1;
          data_d   = entry;
          out_st_d = st_q;
          last_d   = (st_q == ST_LAST);
          if (st_q != ST_LAST) begin
            st_d = st_q + 1'b1;
          end else begin
            st_d = '0;
`ifdef DLSC_DEMOSAIC_VNG_SEQROM_LOOP_EN
            // a start coinciding with the final advance chains the next pass
            if (!in_start) begin
              state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        st_d    = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      st_q     <= '0;
      out_st_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      st_q     <= st_d;
      out_st_q <= out_st_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign out_st    = out_st_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_done  = done_q;
  assign busy      = (state_q == S_RUN);

endmodule

// File: tb/tb_dlsc_demosaic_vng_seqrom.sv
// tb/tb_dlsc_demosaic_vng_seqrom.sv - self-checking bench for dlsc_demosaic_vng_seqrom
module tb_dlsc_demosaic_vng_seqrom;

`ifdef DLSC_DEMOSAIC_VNG_SEQROM_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  // Slot for state s holds {ch1 = 15-s, ch0 = s}, state 0 in the top slot of an n-state ROM
  function automatic logic [95:0] mk_rom(input int n);
    logic [95:0] r;
    r = '0;
    for (int s = 0; s < n; s++) begin
      r[8*(n-1-s) +: 8] = {4'(15-s), 4'(s)};
    end
    return r;
  endfunction

  localparam logic [95:0] ROM12      = mk_rom(12);
  localparam logic [95:0] ROM5_FULL  = mk_rom(5);
  localparam logic [39:0] ROM5       = ROM5_FULL[39:0];

  logic clk = 1'b0;
  logic rst, in_start, in_en;

  logic       a_valid, a_last, a_done, a_busy;
  logic [3:0] a_st;
  logic [7:0] a_data;
  logic       b_valid, b_last, b_done, b_busy;
  logic [3:0] b_st;
  logic [7:0] b_data;

  always #5 clk = ~clk;

  dlsc_demosaic_vng_seqrom #(.DATA(4), .STATES(12), .SB(4), .CHANNELS(2), .ROM(ROM12)) dut (
    .clk(clk), .rst(rst), .in_start(in_start), .in_en(in_en),
    .out_valid(a_valid), .out_st(a_st), .out_data(a_data),
    .out_last(a_last), .out_done(a_done), .busy(a_busy)
  );

  dlsc_demosaic_vng_seqrom #(.DATA(4), .STATES(5), .SB(4), .CHANNELS(2), .ROM(ROM5)) dut5 (
    .clk(clk), .rst(rst), .in_start(in_start), .in_en(in_en),
    .out_valid(b_valid), .out_st(b_st), .out_data(b_data),
    .out_last(b_last), .out_done(b_done), .busy(b_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: pos is the next state index to emit, or -1 when not sequencing
  typedef struct packed {
    int   pos;
    logic valid;
    int   st;
    int   data;
    logic last;
    logic done;
    logic busy;
  } m_t;

  function automatic m_t m_reset();
    m_t m;
    m.pos = -1; m.valid = 0; m.st = 0; m.data = 0; m.last = 0; m.done = 0; m.busy = 0;
    return m;
  endfunction

  function automatic m_t m_step(input m_t m, input int n, input bit r, input bit s, input bit e);
    m_t x;
    if (r) return m_reset();
    x = m;
    x.done  = m.valid && m.last;
    x.valid = 0;
    if (m.pos < 0) begin
      if (s) x.pos = 0;
    end else if (e) begin
      x.valid = 1;
      x.st    = m.pos;
      x.data  = (15 - m.pos) * 16 + m.pos;
      x.last  = (m.pos == n - 1);
      if (m.pos == n - 1) x.pos = (LOOP && s) ? 0 : -1;
      else                x.pos = m.pos + 1;
    end
    x.busy = (x.pos >= 0);
    return x;
  endfunction

  m_t ma, mb;
  int words12 = 0;
  int dones12 = 0;

  // One cycle: check current outputs, then drive inputs and advance the model
  task automatic cyc(input bit r, input bit s, input bit e);
    @(negedge clk);
    check_eq("valid12", a_valid, ma.valid);
    check_eq("st12",    a_st,    ma.st);
    check_eq("data12",  a_data,  ma.data);
    check_eq("last12",  a_last,  ma.last);
    check_eq("done12",  a_done,  ma.done);
    check_eq("busy12",  a_busy,  ma.busy);
    check_eq("valid5",  b_valid, mb.valid);
    check_eq("st5",     b_st,    mb.st);
    check_eq("data5",   b_data,  mb.data);
    check_eq("last5",   b_last,  mb.last);
    check_eq("done5",   b_done,  mb.done);
    check_eq("busy5",   b_busy,  mb.busy);
    if (a_valid === 1'b1) words12++;
    if (a_done === 1'b1) dones12++;
    rst = r; in_start = s; in_en = e;
    ma = m_step(ma, 12, r, s, e);
    mb = m_step(mb, 5, r, s, e);
  endtask

  task automatic run_en(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 1);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0);
  endtask

  initial begin
    rst = 1; in_start = 0; in_en = 0;
    ma = m_reset(); mb = m_reset();
    repeat (3) @(posedge clk);
    cyc(1, 1, 1);
    idle(2);

    // full 12-word sequence
    words12 = 0; dones12 = 0;
    cyc(0, 1, 0);
    run_en(12);
    idle(3);
    check_eq("seq_words", words12, 12);
    check_eq("seq_dones", dones12, 1);

    // stall inside the sequence
    cyc(0, 1, 0);
    cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 1);
    run_en(10);
    idle(3);

    // reset after five advances, then replay
    cyc(0, 1, 0);
    run_en(5);
    cyc(1, 0, 1);
    idle(2);
    cyc(0, 1, 0);
    run_en(12);
    idle(2);

    // start in the middle is ignored; en while idle produces nothing
    words12 = 0;
    cyc(0, 1, 0);
    run_en(6);
    cyc(0, 1, 1);
    run_en(5);
    idle(2);
    run_en(3);
    idle(1);
    check_eq("mid_start_words", words12, 12);

    // start on the final advance
    words12 = 0; dones12 = 0;
    cyc(0, 1, 0);
    run_en(11);
    cyc(0, 1, 1);
    run_en(12);
    idle(3);
    check_eq("loop_words", words12, LOOP ? 24 : 12);
    check_eq("loop_dones", dones12, LOOP ? 2 : 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom % 300) == 0, ($urandom % 6) == 0, ($urandom % 4) != 0);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dlsc_demosaic_vng_seqrom.md
Name: dlsc_demosaic_vng_seqrom

Overview:
- Multi-channel, depth-parametrised coefficient ROM for the VNG demosaic pipeline, with its own state sequencer.
- On a start pulse, walks states 0..STATES-1, advancing one state per enabled cycle, and emits CHANNELS registered coefficient words per state.
- Replaces externally-driven state indexing for the VNG interpolation stages.
- Emits sequence-position flags (last, done) so downstream accumulators can frame each pixel's pass.

Parameters:
- DATA, 4: bits per coefficient word.
- STATES, 12: sequence length; legal range 2..2^SB.
- SB, 4: state counter width; 2^SB >= STATES required.
- CHANNELS, 1: coefficient words emitted per state.
- ROM, 0: width DATA*CHANNELS*STATES.
  - State s entry = ROM[(DATA*CHANNELS*(STATES-1-s)) +: DATA*CHANNELS], so state 0 is the most-significant entry.
  - Channel c = entry[(DATA*c) +: DATA].

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_start  input  1  begin sequence; sampled in IDLE (see optional feature for RUN).
- in_en  input  1  advance one state while RUN.
- out_valid  output  1  out_data/out_st valid this cycle.
- out_st  output  SB  state index of current out_data.
- out_data  output  DATA*CHANNELS  coefficient words for out_st.
- out_last  output  1  high with out_valid when out_st==STATES-1.
- out_done  output  1  one-cycle pulse the cycle after out_last output.
- busy  output  1  high while FSM in RUN.

Behaviour:
- Reset values: FSM=IDLE, internal st=0, out_valid=0, out_st=0, out_data=0, out_last=0, out_done=0, busy=0. Reset mid-sequence aborts immediately, with no done pulse.
- FSM IDLE:
  - in_start=1 -> RUN, st=0, busy=1 next cycle.
  - in_en ignored in IDLE; out_valid=0.
- FSM RUN, cycle with in_en=1:
  - Next cycle: out_data<=entry(st), out_st<=st, out_valid<=1, out_last<=(st==STATES-1).
  - If st<STATES-1: st<=st+1.
  - Else: st<=0, FSM->IDLE.
- FSM RUN, cycle with in_en=0: out_valid<=0; out_data, out_st, out_last hold their previous values; st holds (stall).
- Latency: exactly 1 cycle from an in_en cycle to its out_valid.
- Sequence length: exactly STATES in_en cycles per sequence, stalls allowed anywhere.
- Exit timing:
  - busy falls in the cycle out_last is presented.
  - out_done pulses the following cycle, regardless of in_en.
- Start handling:
  - in_start in RUN is ignored unless the optional feature is enabled.
  - in_start with rst high: reset wins.
- Minimum IDLE gap between sequences is 1 cycle without the feature.
- out_st never exceeds STATES-1, even when STATES < 2^SB.
- ROM lookup is a case/index decode registered once; no combinational path from inputs to outputs.

Optional Feature:
- Macro: DLSC_DEMOSAIC_VNG_SEQROM_LOOP_EN.
- Defined: in_start=1 in the same cycle as the final in_en (st==STATES-1) keeps FSM in RUN with st=0.
  - busy stays 1.
  - out_done still pulses for the completed sequence.
  - Next sequence may start with no bubble.
  - in_start in RUN at any other cycle is ignored.
- Undefined: in_start in RUN always ignored; FSM always returns to IDLE after the final state.

Test Plan:
- Setup: DATA=4, STATES=12, CHANNELS=2; entry s = {ch1=15-s, ch0=s}.
- Pulse in_start, then in_en high for 12 cycles -> out_valid for 12 consecutive cycles with out_data=0xF0,0xE1,...,0x4B; out_last high only with 0x4B; out_done pulses 1 cycle later; busy low from the out_last cycle.
- Stall: in_en pattern 1,0,0,1 over states 0..1 -> out_valid pattern 1,0,0,1; out_data stays 0xF0 through the stall; next valid word is 0xE1.
- Reset asserted after 5 advances -> all outputs 0 next cycle, no out_done; a new start replays from out_st=0.
- in_start pulsed at state 6, in_en continuous -> sequence unaffected, 12 words total; in_en while IDLE produces no out_valid.
- With LOOP_EN, in_start on the final in_en -> 24 consecutive valid words with out_st wrapping 11->0; out_done pulses once between the two sequences; without LOOP_EN, the same stimulus yields 12 words and busy falls.
- STATES=5, SB=4 -> out_st sequence 0..4 only, wraps to IDLE; entries taken from the top 5 ROM slots.
